// File: rtl/lsu_align_pkg.sv
// Shared encodings for the load/store alignment unit: save methods,
// RV32I load/store funct3 values, FSM states and small decode helpers.
package lsu_align_pkg;

  localparam logic [1:0] SM_SB = 2'b00;
  localparam logic [1:0] SM_SH = 2'b01;
  localparam logic [1:0] SM_SW = 2'b10;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_WR0  = 3'd3,
    ST_WR1  = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  // Access size in bytes; funct3[1:0] encodes byte/half/word for both loads and stores.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) f3_legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else    f3_legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                       (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_align_lane_merge.sv
// Byte-lane datapath: merges store bytes into the two buffered words and
// extracts/extends load data from the little-endian {buf1, buf0} stream.
module lsu_lane_merge
  import lsu_align_pkg::*;
(
  input  logic [31:0] buf0_i,
  input  logic [31:0] buf1_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] wr0_o,
  output logic [31:0] wr1_o,
  output logic [31:0] load_o
);

  logic [63:0] stream;
  logic [63:0] shifted_rd;
  logic [63:0] shifted_wd;
  logic [63:0] bit_mask;
  logic [63:0] merged;
  logic [7:0]  lane_mask;
  logic [5:0]  shamt;

  assign stream = {buf1_i, buf0_i};
  assign shamt  = {1'b0, off_i, 3'b000};

  // Store merge: lanes off..off+size-1 of the 8-byte window take the store bytes.
  always_comb begin
    lane_mask = 8'h00;
    case (size_i)
      3'd1:    lane_mask = 8'b0000_0001;
      3'd2:    lane_mask = 8'b0000_0011;
      default: lane_mask = 8'b0000_1111;
    endcase
    lane_mask  = lane_mask << off_i;
    bit_mask   = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[i*8 +: 8] = {8{lane_mask[i]}};
    end
    shifted_wd = {32'h0, wdata_i} << shamt;
    merged     = (stream & ~bit_mask) | (shifted_wd & bit_mask);
    wr0_o      = merged[31:0];
    wr1_o      = merged[63:32];
  end

  // Load extraction with sign or zero extension by funct3.
  always_comb begin
    shifted_rd = stream >> shamt;
    case (funct3_i)
      F3_LB:   load_o = {{24{shifted_rd[7]}}, shifted_rd[7:0]};
      F3_LH:   load_o = {{16{shifted_rd[15]}}, shifted_rd[15:0]};
      F3_LW:   load_o = shifted_rd[31:0];
      F3_LBU:  load_o = {24'h0, shifted_rd[7:0]};
      F3_LHU:  load_o = {16'h0, shifted_rd[15:0]};
      default: load_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: turns byte-addressed RV32I loads/stores into
// full-word memory reads/writes, splitting accesses that cross a word.
module lsu_align
  import lsu_align_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_word_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_save_method,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic              we_q, err_q, cross_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] w0_q;
  logic [31:0]       wdata_q, buf0_q, buf1_q;

  logic [1:0]        req_off;
  logic              req_legal;
  logic              req_cross;
  logic [2:0]        size_q;
  logic [31:0]       wr0, wr1, load_val;
  logic              accept;

  // Address bits above the memory's reach are deliberately ignored.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_off   = req_addr[1:0];
  assign req_legal = f3_legal(req_we, req_funct3);
  assign req_cross = ({2'b00, req_off} + {1'b0, size_bytes(req_funct3)}) > 4'd4;
  assign size_q    = size_bytes(f3_q);
  assign accept    = (state_q == ST_IDLE) && req_valid;

  lsu_lane_merge u_merge (
    .buf0_i   (buf0_q),
    .buf1_i   (buf1_q),
    .off_i    (off_q),
    .size_i   (size_q),
    .funct3_i (f3_q),
    .wdata_i  (wdata_q),
    .wr0_o    (wr0),
    .wr1_o    (wr1),
    .load_o   (load_val)
  );

  // State register, request latch and read-data capture buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cross_q <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      w0_q    <= '0;
      wdata_q <= 32'h0;
      buf0_q  <= 32'h0;
      buf1_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= !req_legal;
        cross_q <= req_cross;
        f3_q    <= req_funct3;
        off_q   <= req_off;
        w0_q    <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
      end
      if (state_q == ST_RD0) buf0_q <= mem_rdata;
      if (state_q == ST_RD1) buf1_q <= mem_rdata;
    end
  end

  // Next-state sequencing of read, write and response phases.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (!req_legal)                                   state_d = ST_RESP;
          else if (!req_we)                                 state_d = ST_RD0;
          else if (req_funct3 == F3_SW && req_off == 2'd0)  state_d = ST_WR0;
          else                                              state_d = ST_RD0;
        end
      end
      ST_RD0:  state_d = cross_q ? ST_RD1 : (we_q ? ST_WR0 : ST_RESP);
      ST_RD1:  state_d = we_q ? ST_WR0 : ST_RESP;
      ST_WR0:  state_d = cross_q ? ST_WR1 : ST_RESP;
      ST_WR1:  state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory and response outputs decoded from the current state.
  always_comb begin
    req_ready       = (state_q == ST_IDLE);
    resp_valid      = (state_q == ST_RESP);
    resp_err        = (state_q == ST_RESP) && err_q;
    resp_rdata      = (state_q == ST_RESP && !we_q && !err_q) ? load_val : 32'h0;
    mem_read        = !rst && (state_q == ST_RD0 || state_q == ST_RD1);
    mem_write       = !rst && (state_q == ST_WR0 || state_q == ST_WR1);
    mem_save_method = SM_SW;
    mem_word_addr   = '0;
    mem_wdata       = 32'h0;
    case (state_q)
      ST_RD0:  mem_word_addr = w0_q;
      ST_RD1:  mem_word_addr = w0_q + 1'b1;
      ST_WR0: begin
        mem_word_addr = w0_q;
        mem_wdata     = wr0;
      end
      ST_WR1: begin
        mem_word_addr = w0_q + 1'b1;
        mem_wdata     = wr1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a word-addressed memory model.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_word_addr;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_save_method;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] tb_mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  int errs   = 0;
  int checks = 0;
  int cyc, nrd, nwr;
  logic both;
  logic [7:0]  rd_addr [0:3];
  logic [7:0]  wr_addr [0:3];
  logic [31:0] wr_data [0:3];

  always #5 clk = ~clk;

  lsu_align #(.ADDR_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_word_addr   (mem_word_addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_save_method (mem_save_method),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  assign mem_rdata = tb_mem[mem_word_addr];

  always_ff @(posedge clk) begin
    if (pre_we)         tb_mem[pre_addr] <= pre_data;
    else if (mem_write) tb_mem[mem_word_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic sample();
    if (mem_read && mem_write) both = 1'b1;
    if (mem_read) begin
      if (nrd < 4) rd_addr[nrd] = mem_word_addr;
      nrd++;
    end
    if (mem_write) begin
      if (nwr < 4) begin
        wr_addr[nwr] = mem_word_addr;
        wr_data[nwr] = mem_wdata;
      end
      nwr++;
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1; nrd = 0; nwr = 0; both = 1'b0;
    sample();
    while (!resp_valid && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
      sample();
    end
    chk({tag, ".lat"},   32'(cyc), 32'(exp_lat));
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    chk({tag, ".err"},   32'(resp_err), 32'(exp_err));
    chk({tag, ".rwx"},   32'(both), 0);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 32'(resp_valid), 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    pre_we = 1'b0; pre_addr = 8'h0; pre_data = 32'h0;

    @(posedge clk); #1;
    chk("rst.ready",  32'(req_ready), 1);
    chk("rst.rvalid", 32'(resp_valid), 0);
    chk("rst.rdata",  resp_rdata, 0);
    chk("rst.err",    32'(resp_err), 0);
    chk("rst.rd",     32'(mem_read), 0);
    chk("rst.wr",     32'(mem_write), 0);
    chk("rst.waddr",  32'(mem_word_addr), 0);
    chk("rst.wdata",  mem_wdata, 0);
    chk("rst.method", 32'(mem_save_method), 2);

    preload(8'd79,  32'h0000_0001);
    preload(8'd80,  32'h0000_0000);
    preload(8'd82,  32'h0000_0000);
    preload(8'd83,  32'h0000_0005);
    preload(8'hFF,  32'h1122_3344);
    preload(8'h00,  32'h1122_3344);
    @(negedge clk); rst = 1'b0;

    // Aligned LW
    do_req("lw", 1'b0, 3'd2, 32'h13C, 32'h0, 2, 32'h0000_0001, 1'b0);
    chk("lw.nrd",  32'(nrd), 1);
    chk("lw.nwr",  32'(nwr), 0);
    chk("lw.addr", 32'(rd_addr[0]), 79);

    // SB then signed/unsigned byte loads
    do_req("sb", 1'b1, 3'd0, 32'h141, 32'h0000_00F5, 3, 32'h0, 1'b0);
    chk("sb.nrd",   32'(nrd), 1);
    chk("sb.nwr",   32'(nwr), 1);
    chk("sb.waddr", 32'(wr_addr[0]), 80);
    chk("sb.wdata", wr_data[0], 32'h0000_F500);
    chk("sb.mem",   tb_mem[80], 32'h0000_F500);
    do_req("lb",  1'b0, 3'd0, 32'h141, 32'h0, 2, 32'hFFFF_FFF5, 1'b0);
    do_req("lbu", 1'b0, 3'd4, 32'h141, 32'h0, 2, 32'h0000_00F5, 1'b0);

    // Crossing LW
    do_req("lwx", 1'b0, 3'd2, 32'h14B, 32'h0, 3, 32'h0000_0500, 1'b0);
    chk("lwx.nrd", 32'(nrd), 2);
    chk("lwx.a0",  32'(rd_addr[0]), 82);
    chk("lwx.a1",  32'(rd_addr[1]), 83);

    // Crossing SW wrapping from word 0xFF to 0x00
    do_req("swx", 1'b1, 3'd2, 32'h3FE, 32'hAABB_CCDD, 5, 32'h0, 1'b0);
    chk("swx.nrd", 32'(nrd), 2);
    chk("swx.nwr", 32'(nwr), 2);
    chk("swx.a0",  32'(wr_addr[0]), 32'hFF);
    chk("swx.d0",  wr_data[0], 32'hCCDD_3344);
    chk("swx.a1",  32'(wr_addr[1]), 0);
    chk("swx.d1",  wr_data[1], 32'h1122_AABB);
    chk("swx.mff", tb_mem[255], 32'hCCDD_3344);
    chk("swx.m00", tb_mem[0],   32'h1122_AABB);

    // Halfword loads across and within the wrapped words
    do_req("lhx", 1'b0, 3'd1, 32'h3FF, 32'h0, 3, 32'hFFFF_BBCC, 1'b0);
    do_req("lhu", 1'b0, 3'd5, 32'h3FE, 32'h0, 2, 32'h0000_CCDD, 1'b0);

    // Aligned SW: single write, no read
    do_req("sw", 1'b1, 3'd2, 32'h148, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
    chk("sw.nrd",  32'(nrd), 0);
    chk("sw.nwr",  32'(nwr), 1);
    chk("sw.data", wr_data[0], 32'hDEAD_BEEF);

    // Illegal funct3 for load and store
    do_req("ild", 1'b0, 3'd3, 32'h13C, 32'h0, 1, 32'h0, 1'b1);
    chk("ild.mem", 32'(nrd + nwr), 0);
    do_req("ist", 1'b1, 3'd4, 32'h13C, 32'h1234_5678, 1, 32'h0, 1'b1);
    chk("ist.mem", 32'(nrd + nwr), 0);

    // Reset during WR0 of an SH
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h13E; req_wdata = 32'h0000_BEEF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rsth.rd0", 32'(mem_read), 1);
    @(posedge clk); #1;
    chk("rsth.wr0", 32'(mem_write), 1);
    rst = 1'b1;
    #1;
    chk("rsth.gate", 32'(mem_write), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rsth.ready", 32'(req_ready), 1);
    chk("rsth.rvld",  32'(resp_valid), 0);
    chk("rsth.mem",   tb_mem[79], 32'h0000_0001);
    @(posedge clk); #1;
    chk("rsth.rvld2", 32'(resp_valid), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
